// File: rtl/ikaopll_pkg.sv
// Shared IKAOPLL definitions: write-sequencer state encoding and default bus timing.
package ikaopll_pkg;

    localparam int WR_PULSE_DEF  = 2;
    localparam int ADDR_WAIT_DEF = 12;
    localparam int DATA_WAIT_DEF = 84;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SET,
        ST_A_STB,
        ST_A_WAIT,
        ST_D_SET,
        ST_D_STB,
        ST_D_WAIT
    } wr_state_e;

    // The shared down-counter only ever holds (duration - 1), so it needs clog2(longest) bits.
    function automatic int timer_width(input int wr_pulse, input int addr_wait, input int data_wait);
        int longest;
        longest = wr_pulse;
        if (addr_wait > longest) longest = addr_wait;
        if (data_wait > longest) longest = data_wait;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/ikaopll_wrfifo.sv
// First-word-fall-through write queue: head entry is visible combinationally from storage.
module ikaopll_wrfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_cnt,
    output logic                   o_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             push_ok;
    logic             pop_ok;

    // Ready is a flop so it stays low through reset and rises one edge after release.
    always_comb begin
        push_ok  = i_push && ready_q;
        pop_ok   = i_pop && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        ready_d  = (cnt_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_cnt   = cnt_q;
    assign o_ready = ready_q;

endmodule

// File: rtl/ikaopll_write_sequencer.sv
// Queues host register writes and replays them to the OPLL core as paced address/data strobes.
module ikaopll_write_sequencer
    import ikaopll_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_PULSE   = WR_PULSE_DEF,
    parameter int ADDR_WAIT  = ADDR_WAIT_DEF,
    parameter int DATA_WAIT  = DATA_WAIT_DEF
) (
    input  logic                        i_EMUCLK,
    input  logic                        i_RST,
    input  logic                        i_phiM_PCEN_n,
    input  logic                        i_REQ_VALID,
    output logic                        o_REQ_READY,
    input  logic [7:0]                  i_REQ_ADDR,
    input  logic [7:0]                  i_REQ_DATA,
    output logic                        o_CS_n,
    output logic                        o_WR_n,
    output logic                        o_A0,
    output logic [7:0]                  o_D,
    output logic                        o_BUSY,
    output logic [$clog2(FIFO_DEPTH):0] o_FIFO_CNT
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = timer_width(WR_PULSE, ADDR_WAIT, DATA_WAIT);
    localparam logic [TMR_W-1:0] WP_LOAD = TMR_W'(WR_PULSE - 1);
    localparam logic [TMR_W-1:0] AW_LOAD = TMR_W'(ADDR_WAIT - 1);
    localparam logic [TMR_W-1:0] DW_LOAD = TMR_W'(DATA_WAIT - 1);

    wr_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       hold_q, hold_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;
    logic             a0_q, a0_d;
    logic [7:0]       d_q, d_d;
    logic             busy_q, busy_d;

    logic             phi_en;
    logic             pop;
    logic             push_fire;
    logic             fifo_ready;
    logic             fifo_nonempty;
    logic [15:0]      fifo_head;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] fifo_cnt_nxt;

    ikaopll_wrfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .i_clk   (i_EMUCLK),
        .i_rst   (i_RST),
        .i_push  (i_REQ_VALID),
        .i_wdata ({i_REQ_ADDR, i_REQ_DATA}),
        .i_pop   (pop),
        .o_rdata (fifo_head),
        .o_cnt   (fifo_cnt),
        .o_ready (fifo_ready)
    );

    assign phi_en        = !i_phiM_PCEN_n;
    assign push_fire     = i_REQ_VALID && fifo_ready;
    assign fifo_nonempty = (fifo_cnt != '0);
    assign fifo_cnt_nxt  = fifo_cnt + CNT_W'(push_fire) - CNT_W'(pop);

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hold_d  = hold_q;
        cs_n_d  = cs_n_q;
        wr_n_d  = wr_n_q;
        a0_d    = a0_q;
        d_d     = d_q;
        pop     = 1'b0;

        if (phi_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    pop = fifo_nonempty;
                end
                ST_A_SET, ST_D_SET: begin
                    state_d = (state_q == ST_A_SET) ? ST_A_STB : ST_D_STB;
                    timer_d = WP_LOAD;
                    cs_n_d  = 1'b0;
                    wr_n_d  = 1'b0;
                end
                ST_A_STB, ST_D_STB: begin
                    if (timer_q == '0) begin
                        state_d = (state_q == ST_A_STB) ? ST_A_WAIT : ST_D_WAIT;
                        timer_d = (state_q == ST_A_STB) ? AW_LOAD : DW_LOAD;
                        cs_n_d  = 1'b1;
                        wr_n_d  = 1'b1;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ST_A_WAIT: begin
                    if (timer_q == '0) begin
                        state_d = ST_D_SET;
                        a0_d    = 1'b1;
                        d_d     = hold_q;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ST_D_WAIT: begin
                    if (timer_q == '0) begin
                        state_d = ST_IDLE;
                        pop     = fifo_nonempty;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Chaining straight out of D_WAIT avoids a dead idle enable between writes.
            if (pop) begin
                state_d = ST_A_SET;
                a0_d    = 1'b0;
                d_d     = fifo_head[15:8];
                hold_d  = fifo_head[7:0];
            end
        end

        busy_d = (state_d != ST_IDLE) || (fifo_cnt_nxt != '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            hold_q  <= '0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            a0_q    <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            a0_q    <= a0_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
        end
    end

    assign o_REQ_READY = fifo_ready;
    assign o_FIFO_CNT  = fifo_cnt;
    assign o_CS_n      = cs_n_q;
    assign o_WR_n      = wr_n_q;
    assign o_A0        = a0_q;
    assign o_D         = d_q;
    assign o_BUSY      = busy_q;

endmodule
